// File: rtl/gelato_compute_task_if.sv
// gelato_compute_task_if: scheduler-to-ALU compute task handshake; GELATO_ALU_MASK_EN adds thread_mask
interface gelato_compute_task_if #(
  parameter int THREAD_NUM = 32,
  parameter int DATA_WIDTH = 32
);
  logic                             valid;
  logic [3:0]                       op;
  logic [THREAD_NUM*DATA_WIDTH-1:0] rs1;
  logic [THREAD_NUM*DATA_WIDTH-1:0] rs2;
  logic                             done;
  logic [THREAD_NUM*DATA_WIDTH-1:0] rd;
`ifdef GELATO_ALU_MASK_EN
  logic [THREAD_NUM-1:0]            thread_mask;
  modport master (output valid, op, rs1, rs2, thread_mask, input done, rd);
  modport slave  (input valid, op, rs1, rs2, thread_mask, output done, rd);
`else
  modport master (output valid, op, rs1, rs2, input done, rd);
  modport slave  (input valid, op, rs1, rs2, output done, rd);
`endif
endinterface

// File: rtl/gelato_compute_alu.sv
// gelato_compute_alu: SIMT integer ALU evaluating a warp LANE_NUM threads per cycle; GELATO_ALU_MASK_EN adds a per-thread mask
module gelato_compute_alu #(
  parameter int THREAD_NUM = 32,
  parameter int LANE_NUM   = 8,
  parameter int DATA_WIDTH = 32
) (
  input logic                   clk,
  input logic                   rst_n,
  input logic                   rdy,
  gelato_compute_task_if.slave  task_if
);
  localparam int S   = THREAD_NUM / LANE_NUM;
  localparam int CW  = S > 1 ? $clog2(S) : 1;
  localparam int SHW = $clog2(DATA_WIDTH);
  localparam int W   = THREAD_NUM * DATA_WIDTH;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_SLL = 4'd2;
  localparam logic [3:0] OP_LT  = 4'd3;
  localparam logic [3:0] OP_LTU = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;
  localparam logic [3:0] OP_OR  = 4'd8;
  localparam logic [3:0] OP_AND = 4'd9;
  typedef enum logic [1:0] {IDLE, BUSY, DONE, RELEASE} state_t;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d, nxt_k, first_k;
  logic                  last;
  logic [3:0]            op_q, op_d;
  logic [W-1:0]          rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic                  done_q, done_d;
  logic [THREAD_NUM-1:0] lane_en, in_mask;
  logic [S-1:0]          act;
`ifdef GELATO_ALU_MASK_EN
  logic [THREAD_NUM-1:0] mask_q, mask_d;
  assign lane_en = mask_q;
  assign in_mask = task_if.thread_mask;
`else
  assign lane_en = '1;
  assign in_mask = '1;
`endif
  assign task_if.done = done_q;
  assign task_if.rd   = rd_q;
  function automatic logic [DATA_WIDTH-1:0] alu(input logic [3:0] op, input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    case (op)
      OP_ADD:  alu = a + b;
      OP_SUB:  alu = a - b;
      OP_SLL:  alu = a << sh;
      OP_LT:   alu = {{(DATA_WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_LTU:  alu = {{(DATA_WIDTH-1){1'b0}}, a < b};
      OP_XOR:  alu = a ^ b;
      OP_SRL:  alu = a >> sh;
      OP_SRA:  alu = $unsigned($signed(a) >>> sh);
      OP_OR:   alu = a | b;
      OP_AND:  alu = a & b;
      default: alu = '0;
    endcase
  endfunction
  // Slice activity, first slice at accept and next slice to visit; fully masked slices are skipped
  always_comb begin
    act     = '0;
    first_k = '0;
    nxt_k   = cnt_q;
    last    = 1'b1;
    for (int j = S - 1; j >= 0; j--) begin
      act[j] = |lane_en[j*LANE_NUM +: LANE_NUM];
      if (|in_mask[j*LANE_NUM +: LANE_NUM]) first_k = CW'(j);
      if (CW'(j) > cnt_q && act[j]) begin
        nxt_k = CW'(j);
        last  = 1'b0;
      end
    end
  end
  // Register update; rdy low freezes every piece of state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      done_q  <= 1'b0;
`ifdef GELATO_ALU_MASK_EN
      mask_q  <= '0;
`endif
    end else if (rdy) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
`ifdef GELATO_ALU_MASK_EN
      mask_q  <= mask_d;
`endif
    end
  end
  // Next state: RELEASE waits for valid to drop so a held task is not run twice
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = task_if.valid ? BUSY : IDLE;
      BUSY:    state_d = last ? DONE : BUSY;
      DONE:    state_d = RELEASE;
      RELEASE: state_d = task_if.valid ? RELEASE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Operand latch, slice evaluation and the done pulse
  always_comb begin
    op_d   = op_q;
    rs1_d  = rs1_q;
    rs2_d  = rs2_q;
    cnt_d  = cnt_q;
    rd_d   = rd_q;
    done_d = done_q;
`ifdef GELATO_ALU_MASK_EN
    mask_d = mask_q;
`endif
    case (state_q)
      IDLE: if (task_if.valid) begin
        op_d  = task_if.op;
        rs1_d = task_if.rs1;
        rs2_d = task_if.rs2;
        cnt_d = first_k;
`ifdef GELATO_ALU_MASK_EN
        mask_d = task_if.thread_mask;
`endif
      end
      BUSY: begin
        cnt_d  = nxt_k;
        done_d = last;
        for (int t = 0; t < THREAD_NUM; t++) begin
          if (CW'(t / LANE_NUM) == cnt_q)
            rd_d[t*DATA_WIDTH +: DATA_WIDTH] = lane_en[t] ? alu(op_q, rs1_q[t*DATA_WIDTH +: DATA_WIDTH], rs2_q[t*DATA_WIDTH +: DATA_WIDTH]) : '0;
          else if (!act[t / LANE_NUM])
            rd_d[t*DATA_WIDTH +: DATA_WIDTH] = '0;
        end
      end
      DONE:    done_d = 1'b0;
      default: done_d = done_q;
    endcase
  end
endmodule

// File: tb/tb_gelato_compute_alu.sv
// tb_gelato_compute_alu: scoreboard bench for gelato_compute_alu; mask tests build with GELATO_ALU_MASK_EN
module tb_gelato_compute_alu;
  localparam int TN = 32;
  localparam int LN = 8;
  localparam int DW = 32;
  localparam int W  = TN * DW;
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, LT = 4'd3, LTU = 4'd4;
  localparam logic [3:0] XOR = 4'd5, SRL = 4'd6, SRA = 4'd7, OR = 4'd8, AND = 4'd9;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b1;
  int cyc = 0;
  int errs = 0;
  int checks = 0;
  logic [W-1:0] sb[$];
  logic [W-1:0] exp_rd, a, b;
  gelato_compute_task_if #(.THREAD_NUM(TN), .DATA_WIDTH(DW)) tif ();
  gelato_compute_alu #(.THREAD_NUM(TN), .LANE_NUM(LN), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .task_if(tif)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y, input logic [TN-1:0] m);
    logic [W-1:0] r;
    logic [31:0] p, q, v, ones;
    ones = 32'hFFFF_FFFF;
    for (int t = 0; t < TN; t++) begin
      p = x[t*32 +: 32];
      q = y[t*32 +: 32];
      case (op)
        ADD:     v = p + q;
        SUB:     v = p + ~q + 32'd1;
        SLL:     v = p << q[4:0];
        LT:      v = (p[31] != q[31]) ? {31'd0, p[31]} : {31'd0, p < q};
        LTU:     v = {31'd0, p < q};
        XOR:     v = p ^ q;
        SRL:     v = p >> q[4:0];
        SRA:     v = (p >> q[4:0]) | (p[31] ? ~(ones >> q[4:0]) : 32'd0);
        OR:      v = p | q;
        AND:     v = p & q;
        default: v = 32'd0;
      endcase
      r[t*32 +: 32] = m[t] ? v : 32'd0;
    end
    return r;
  endfunction
  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    for (int t = 0; t < TN; t++) r[t*32 +: 32] = $urandom();
    return r;
  endfunction
  always @(negedge clk) begin
    if (rst_n && tif.done) begin
      if (sb.size() == 0) chk("spurious_done", 64'd1, 64'd0);
      else begin
        exp_rd = sb.pop_front();
        for (int t = 0; t < TN; t++) chk($sformatf("rd_t%0d", t), {32'd0, tif.rd[t*DW +: DW]}, {32'd0, exp_rd[t*DW +: DW]});
      end
    end
  end
  task automatic run(input string tag, input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic [TN-1:0] m, input int stall, input int lat, input int hold);
    int c0;
    bit seen;
    seen = 1'b0;
    tif.op = op;
    tif.rs1 = x;
    tif.rs2 = y;
    tif.valid = 1'b1;
`ifdef GELATO_ALU_MASK_EN
    tif.thread_mask = m;
`endif
    sb.push_back(model(op, x, y, m));
    c0 = cyc;
    for (int i = 1; i <= 60 && !seen; i++) begin
      @(negedge clk);
      if (i == 1) begin
        tif.rs1 = ~x;
        tif.rs2 = x ^ y;
        tif.op = op ^ 4'h3;
`ifdef GELATO_ALU_MASK_EN
        tif.thread_mask = ~m;
`endif
      end
      if (stall > 0 && i == 2) rdy = 1'b0;
      if (stall > 0 && i == 2 + stall) rdy = 1'b1;
      if (tif.done) begin
        seen = 1'b1;
        chk({tag, "_lat"}, 64'(cyc - c0), 64'(lat));
      end
    end
    if (!seen) chk({tag, "_timeout"}, 64'd0, 64'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold"}, {63'd0, tif.done}, 64'd0);
    end
    tif.valid = 1'b0;
    @(negedge clk);
    chk({tag, "_pulse"}, {63'd0, tif.done}, 64'd0);
    @(negedge clk);
  endtask
  initial begin
    tif.valid = 1'b0;
    tif.op = '0;
    tif.rs1 = '0;
    tif.rs2 = '0;
`ifdef GELATO_ALU_MASK_EN
    tif.thread_mask = '1;
`endif
    repeat (2) @(negedge clk);
    chk("rst_done", {63'd0, tif.done}, 64'd0);
    for (int t = 0; t < TN; t += 7) chk($sformatf("rst_rd_t%0d", t), {32'd0, tif.rd[t*DW +: DW]}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int t = 0; t < TN; t++) a[t*32 +: 32] = t;
    b = '1;
    run("add", ADD, a, b, '1, 0, 5, 0);
    run("sra", SRA, {TN{32'h8000_0000}}, {TN{32'h0000_0024}}, '1, 0, 5, 0);
    run("srl", SRL, {TN{32'h8000_0000}}, {TN{32'h0000_0024}}, '1, 0, 5, 0);
    run("lt", LT, {TN{32'hFFFF_FFFF}}, {TN{32'h0000_0001}}, '1, 0, 5, 0);
    run("ltu", LTU, {TN{32'hFFFF_FFFF}}, {TN{32'h0000_0001}}, '1, 0, 5, 0);
    run("sub", SUB, rnd(), rnd(), '1, 0, 5, 0);
    run("undef", 4'hB, rnd(), rnd(), '1, 0, 5, 0);
    for (int k = 0; k < 6; k++) run("rand", 4'($urandom_range(0, 10)), rnd(), rnd(), '1, 0, 5, 0);
    run("held", OR, rnd(), rnd(), '1, 0, 5, 3);
    run("rearm", SLL, rnd(), rnd(), '1, 0, 5, 0);
    run("stall", XOR, rnd(), rnd(), '1, 2, 7, 0);
    tif.op = ADD;
    tif.rs1 = {TN{32'd1}};
    tif.rs2 = {TN{32'd1}};
    tif.valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("busy_rd_t0", {32'd0, tif.rd[31:0]}, 64'd2);
    rst_n = 1'b0;
    #1;
    chk("arst_done", {63'd0, tif.done}, 64'd0);
    for (int t = 0; t < TN; t += 5) chk($sformatf("arst_rd_t%0d", t), {32'd0, tif.rd[t*DW +: DW]}, 64'd0);
    tif.valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run("post_rst", AND, rnd(), rnd(), '1, 0, 5, 0);
`ifdef GELATO_ALU_MASK_EN
    run("mask_ff", AND, rnd(), rnd(), 32'h0000_00FF, 0, 2, 0);
    run("mask_zero", ADD, rnd(), rnd(), 32'h0000_0000, 0, 2, 0);
    run("mask_mid", ADD, rnd(), rnd(), 32'h00F0_0100, 0, 3, 0);
`endif
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule

// File: doc/gelato_compute_alu.md
Name: gelato_compute_alu

Overview:
- SIMT integer ALU that sits directly downstream of the compute-unit scheduler.
- Slave side of gelato_compute_task_if: accepts a per-warp task (rs1, rs2, op), evaluates all THREAD_NUM lanes and returns rd with a one-cycle done pulse.
- Processes LANE_NUM threads per cycle over THREAD_NUM/LANE_NUM slices, trading latency for area.

Parameters:
- THREAD_NUM, 32, threads per warp (equals `THREAD_NUM).
- LANE_NUM, 8, physical ALU lanes; THREAD_NUM % LANE_NUM == 0, power of two.
- DATA_WIDTH, 32, bits per thread operand.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rdy  input  1  global enable; low = hold all state.
- task_valid  input  1  compute_task.valid; held high by the scheduler until it sees done.
- task_op  input  4  compute_task.op: ADD, SUB, SLL, LT, LTU, XOR, SRL, SRA, OR, AND (gelato_types enum).
- task_rs1  input  THREAD_NUM*DATA_WIDTH  operand A, thread t at bits [t*32 +: 32].
- task_rs2  input  THREAD_NUM*DATA_WIDTH  operand B, same packing.
- task_done  output  1  compute_task.done, one-cycle pulse.
- task_rd  output  THREAD_NUM*DATA_WIDTH  compute_task.rd result.

Interface decision: one clock (clk), asynchronous active-low reset (rst_n). These ports are the compute_task_if slave modport flattened.

Behaviour:
- Reset (async, any state, including mid-task): state=IDLE, slice counter=0, task_done=0, task_rd=0, latched operands=0.
- rdy=0: no state, counter or output change. task_done holds its current value.
- States:
  - IDLE: on an edge with task_valid=1, latch op/rs1/rs2, set counter=0, go to BUSY.
  - BUSY: each edge computes slice k (threads k*LANE_NUM to k*LANE_NUM+LANE_NUM-1) from the latched operands into task_rd, then k++. On the edge that computes the last slice (k=S-1, S=THREAD_NUM/LANE_NUM), go to DONE and set task_done<=1.
  - DONE: task_done=1 for exactly one cycle; next edge clears task_done and goes to RELEASE.
  - RELEASE: wait for task_valid=0, then go to IDLE. This prevents re-execution of a still-asserted task.
- Latency: valid first high in cycle 0 gives task_done high in cycle S+1 (5 cycles at defaults). Throughput is one task per S+3 cycles minimum.
- Operands are latched at accept. Input changes during BUSY are ignored.
- task_rd:
  - Slices not yet computed keep their previous values.
  - The full task_rd is stable from the task_done cycle until the next accept.
- Arithmetic, per 32-bit lane:
  - ADD and SUB wrap modulo 2^32.
  - SLL, SRL, SRA use rs2[4:0] only; SRA is arithmetic.
  - LT is signed, LTU is unsigned; both produce 32'd1 or 32'd0.
  - XOR, OR, AND are bitwise.
  - Any undefined op encoding gives lane result 0 (no $fatal).
- task_valid dropping during BUSY has no effect; the task completes and done still pulses.

Optional Feature:
- Macro GELATO_ALU_MASK_EN.
- Defined:
  - Adds input task_thread_mask [THREAD_NUM-1:0], latched at accept.
  - A slice whose mask bits are all zero is skipped, so the counter advances past it with no cycle spent.
  - Inactive lanes write 0 into task_rd.
  - An all-zero mask goes IDLE to DONE via one BUSY cycle, giving done in cycle 2.
- Undefined: no mask port; every lane is processed and latency is always S+1.

Test Plan:
- ADD, rs1 lanes=t, rs2 lanes=0xFFFF_FFFF -> done in cycle 5 only; rd lane t = t-1 (lane 0 = 0xFFFF_FFFF).
- SRA rs1=0x8000_0000, rs2=0x24 -> every lane 0xF800_0000 (shift 4); SRL same operands -> 0x0800_0000.
- LT vs LTU, rs1=0xFFFF_FFFF, rs2=1 -> LT gives 1, LTU gives 0.
- Hold task_valid high 3 cycles after done -> no second done; drop valid, reassert -> new done exactly 5 cycles later.
- rdy=0 for 2 cycles during BUSY -> done delayed to cycle 7, rd identical; assert rst_n=0 in BUSY -> task_done=0 and task_rd=0 immediately.
- GELATO_ALU_MASK_EN, mask=0x0000_00FF, AND op -> done in cycle 2; lanes 8-31 = 0.
